// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-unit definitions: chip-enable levels, default address width and vectors,
// and the fetch state encoding.
package pc_fetch_ctrl_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned DEF_INST_BYTES = 4;

    localparam logic [INST_ADDR_W-1:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] DEF_EXC_VEC   = 32'h0000_0020;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational next-fetch-address priority select: exception > branch > pending > sequential.
// A branch whose target is not instruction-aligned is promoted to an exception redirect.
module pc_redirect_sel import pc_fetch_ctrl_pkg::*; #(
    parameter int unsigned           ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0]     EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned           INST_BYTES = DEF_INST_BYTES
) (
    input  logic              exc_valid_i,
    input  logic              br_valid_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              pend_valid_i,
    input  logic [ADDR_W-1:0] pend_addr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              misaligned_o,
    output logic              take_exc_o,
    output logic              take_br_o,
    output logic [ADDR_W-1:0] target_o
);

    // INST_BYTES is a power of two, so its low-bit mask covers exactly the offset bits.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

    assign misaligned_o = br_valid_i && ((br_target_i & ALIGN_MASK) != '0);
    assign take_exc_o   = exc_valid_i | misaligned_o;
    assign take_br_o    = br_valid_i & ~misaligned_o;

    always_comb begin
        target_o = pc_i + STEP;
        if (take_exc_o) begin
            target_o = EXC_VEC;
        end else if (take_br_o) begin
            target_o = br_target_i;
        end else if (pend_valid_i) begin
            target_o = pend_addr_i;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request unit with valid/ready handshake, stall,
// halt, and branch/exception redirects held pending until the next accepted fetch.
module pc_fetch_ctrl import pc_fetch_ctrl_pkg::*; #(
    parameter int unsigned       ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       INST_BYTES = DEF_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic              imem_ready,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic              badaddr_valid,
    output logic [ADDR_W-1:0] badaddr
);

    typedef struct packed {
        logic              vld;
        logic              is_exc;
        logic [ADDR_W-1:0] addr;
    } pend_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    pend_t             pend_q, pend_d;
    logic              badaddr_vld_q, badaddr_vld_d;
    logic [ADDR_W-1:0] badaddr_q, badaddr_d;

    logic              accept;
    logic              misaligned;
    logic              take_exc;
    logic              take_br;
    logic [ADDR_W-1:0] sel_target;

    pc_redirect_sel #(
        .ADDR_W     (ADDR_W),
        .EXC_VEC    (EXC_VEC),
        .INST_BYTES (INST_BYTES)
    ) u_redirect_sel (
        .exc_valid_i  (exc_valid),
        .br_valid_i   (br_valid),
        .br_target_i  (br_target),
        .pend_valid_i (pend_q.vld),
        .pend_addr_i  (pend_q.addr),
        .pc_i         (pc_q),
        .misaligned_o (misaligned),
        .take_exc_o   (take_exc),
        .take_br_o    (take_br),
        .target_o     (sel_target)
    );

    always_comb begin
        state_d = state_q;
        ce      = CHIP_DISABLE;
        case (state_q)
            IDLE: state_d = halt ? HALT : RUN;
            RUN: begin
                ce = CHIP_ENABLE;
                if (halt) state_d = HALT;
            end
            HALT: if (!halt) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign accept = ce & imem_ready & ~stall;

    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        badaddr_vld_d = misaligned;
        badaddr_d     = misaligned ? br_target : badaddr_q;
        if (accept) begin
            pc_d   = sel_target;
            pend_d = '0;
        end else if (take_exc) begin
            pend_d = '{vld: 1'b1, is_exc: 1'b1, addr: EXC_VEC};
        end else if (take_br && !(pend_q.vld && pend_q.is_exc)) begin
            // A queued exception must not be lost to a later branch.
            pend_d = '{vld: 1'b1, is_exc: 1'b0, addr: br_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VEC;
            pend_q        <= '0;
            badaddr_vld_q <= 1'b0;
            badaddr_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            badaddr_vld_q <= badaddr_vld_d;
            badaddr_q     <= badaddr_d;
        end
    end

    assign pc            = pc_q;
    assign badaddr_valid = badaddr_vld_q;
    assign badaddr       = badaddr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a 32-bit instance for the main sequence and an
// 8-bit instance for address wrap-around.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, halt, br_valid, exc_valid, imem_ready;
    logic [31:0] br_target;
    logic        ce, badaddr_valid;
    logic [31:0] pc, badaddr;

    logic        rst8, stall8, halt8, br_valid8, exc_valid8, imem_ready8;
    logic [7:0]  br_target8;
    logic        ce8, badaddr_valid8;
    logic [7:0]  pc8, badaddr8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .halt          (halt),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .exc_valid     (exc_valid),
        .imem_ready    (imem_ready),
        .ce            (ce),
        .pc            (pc),
        .badaddr_valid (badaddr_valid),
        .badaddr       (badaddr)
    );

    pc_fetch_ctrl #(
        .ADDR_W     (8),
        .RESET_VEC  (8'h00),
        .EXC_VEC    (8'h20),
        .INST_BYTES (4)
    ) dut8 (
        .clk           (clk),
        .rst           (rst8),
        .stall         (stall8),
        .halt          (halt8),
        .br_valid      (br_valid8),
        .br_target     (br_target8),
        .exc_valid     (exc_valid8),
        .imem_ready    (imem_ready8),
        .ce            (ce8),
        .pc            (pc8),
        .badaddr_valid (badaddr_valid8),
        .badaddr       (badaddr8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; stall = 0; halt = 0; br_valid = 0; br_target = '0;
        exc_valid = 0; imem_ready = 1;
        rst8 = 1; stall8 = 0; halt8 = 0; br_valid8 = 0; br_target8 = '0;
        exc_valid8 = 0; imem_ready8 = 1;

        tick(); tick();
        chk("rst_ce", ce, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_bav", badaddr_valid, 0);
        chk("rst_ba", badaddr, 32'h0);

        // Sequential fetch after release
        rst = 0;
        chk("idle_ce", ce, 0);
        tick(); chk("run_ce", ce, 1); chk("seq_pc0", pc, 32'h0);
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); tick(); chk("seq_pc10", pc, 32'h10);

        // Branch taken with accept
        br_valid = 1; br_target = 32'h100;
        tick(); chk("br_pc", pc, 32'h100);
        br_valid = 0;
        tick(); chk("br_seq", pc, 32'h104);

        // Branch held pending while imem not ready
        br_valid = 1; br_target = 32'h20;
        tick(); chk("to20", pc, 32'h20);
        imem_ready = 0; br_target = 32'h200;
        tick(); chk("hold1", pc, 32'h20);
        br_valid = 0;
        tick(); chk("hold2", pc, 32'h20);
        tick(); chk("hold3", pc, 32'h20); chk("hold_ce", ce, 1);
        imem_ready = 1;
        tick(); chk("pend_br", pc, 32'h200);
        tick(); chk("pend_clr", pc, 32'h204);

        // Pending exception not overwritten by later branch
        imem_ready = 0; br_valid = 1; br_target = 32'h200;
        tick();
        br_valid = 0; exc_valid = 1;
        tick();
        exc_valid = 0; br_valid = 1; br_target = 32'h300;
        tick();
        br_valid = 0;
        chk("pexc_hold", pc, 32'h204);
        imem_ready = 1;
        tick(); chk("pexc_pc", pc, 32'h20);
        tick(); chk("pexc_clr", pc, 32'h24);

        // Exception beats branch in same cycle
        exc_valid = 1; br_valid = 1; br_target = 32'h80;
        tick(); chk("exc_pri", pc, 32'h20);
        exc_valid = 0; br_valid = 0;
        tick(); chk("exc_seq", pc, 32'h24);

        // Misaligned branch target
        br_valid = 1; br_target = 32'h102;
        tick(); chk("mis_pc", pc, 32'h20); chk("mis_bav", badaddr_valid, 1);
        chk("mis_ba", badaddr, 32'h102);
        br_valid = 0;
        tick(); chk("mis_pc2", pc, 32'h24); chk("mis_bav0", badaddr_valid, 0);
        chk("mis_ba_hold", badaddr, 32'h102);

        // Stall blocks acceptance
        stall = 1;
        tick(); chk("stall_pc", pc, 32'h24);
        stall = 0;
        tick(); chk("unstall_pc", pc, 32'h28);

        // Halt while not accepted: pc and pending retained
        imem_ready = 0; halt = 1; br_valid = 1; br_target = 32'h400;
        tick(); chk("halt_ce", ce, 0); chk("halt_pc", pc, 32'h28);
        br_valid = 0;
        tick(); chk("halt_ce2", ce, 0); chk("halt_pc2", pc, 32'h28);
        halt = 0; imem_ready = 1;
        tick(); chk("resume_ce", ce, 1); chk("resume_pc", pc, 32'h28);
        tick(); chk("resume_pend", pc, 32'h400);

        // Reset during halt clears pending
        halt = 1; imem_ready = 0; br_valid = 1; br_target = 32'h500;
        tick(); chk("halt3_ce", ce, 0);
        br_valid = 0; rst = 1;
        tick(); chk("rsth_pc", pc, 32'h0); chk("rsth_ce", ce, 0);
        rst = 0; halt = 0; imem_ready = 1;
        tick(); chk("rsth_run", ce, 1); chk("rsth_pc0", pc, 32'h0);
        tick(); chk("rsth_nopend", pc, 32'h4);

        // 8-bit wrap-around
        rst8 = 0;
        tick(); chk("w8_ce", ce8, 1); chk("w8_pc0", pc8, 8'h00);
        br_valid8 = 1; br_target8 = 8'hFC;
        tick(); chk("w8_pcFC", pc8, 8'hFC);
        br_valid8 = 0;
        tick(); chk("w8_wrap", pc8, 8'h00);
        tick(); chk("w8_pc4", pc8, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
